piso_shift_transmitter: RTL
===========================

# piso_shift_transmitter

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a ready/valid handshake and shifts it out LSB-first, one bit per clock. It sits upstream of the team's serial-in shift registers, which consume the stream. A frame strobe marks valid bits, and a done pulse marks the end of each word. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8, data word width; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle (combinational from state).
- sout  output  WIDTH-independent 1  serial data, registered; LSB first.
- sframe  output  1  registered; high in every cycle where sout carries a frame bit.
- done  output  1  registered; one-cycle pulse after the final bit of a frame.

## Operation
- Handshake: a word is accepted on a rising edge where din_valid && din_ready. While din_ready=0, din_valid is ignored, and the upstream must hold din and din_valid until acceptance.
- Internal state:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, $clog2(WIDTH) bits
  - FSM state with values IDLE, SHIFT, PAR (PAR exists only with the parity macro)
- On accept:
  - sout <= din[0], sframe <= 1, sreg <= din >> 1, cnt <= 0, state <= SHIFT.
  - When parity is enabled, the parity bit is latched as ^din.
- In SHIFT, each edge with cnt < WIDTH-1 does sout <= sreg[0], sreg <= sreg >> 1 (right shift, zero fill), cnt <= cnt+1.
- At the edge ending the last data bit (cnt == WIDTH-1), the next step depends on parity.
  - Without parity:
    - If a new word is accepted at this edge, perform the accept actions and raise done.
    - Otherwise, sout <= 0, sframe <= 0, done <= 1, state <= IDLE.
  - With parity: sout <= latched parity, sframe stays 1, state <= PAR.
- At the edge ending PAR, the same choice applies: accept a new word, or go to IDLE with sout=0, sframe=0. done <= 1 in both cases.
- din_ready =
  - (state==IDLE && !rst)
  - || (state==SHIFT && cnt==WIDTH-1 && parity disabled)
  - || (state==PAR).
- Idle line: sout=0 and sframe=0 whenever no frame is active.
- done is low in every cycle it is not explicitly pulsed.

## Timing
- Reset values: state=IDLE, sout=0, sframe=0, done=0, sreg=0, cnt=0.
- din_ready=0 while rst is high, and 1 from the first cycle after release.
- Latency: bit 0 appears on sout in the cycle after the accepting edge.
- Frame length:
  - WIDTH cycles of sframe without parity.
  - WIDTH+1 cycles with parity.
- done is high for exactly one cycle: the cycle immediately after the last frame bit. This is also the first bit cycle of the next frame when streaming.
- Streaming throughput: one word per WIDTH cycles (WIDTH+1 with parity). sframe stays continuously high across words.
- Reset mid-frame aborts the frame immediately. No done pulse follows, the partial word is discarded, and the next frame restarts from bit 0.
- A din_valid edge coinciding with rst release is not accepted; the first accept is possible at the following edge.

## Configuration
- PISO_PARITY_EN defined:
  - One even-parity bit (^data) is appended after the MSB.
  - The PAR state is present.
  - Frame length is WIDTH+1.
  - din_ready is asserted during PAR instead of during the last data bit.
- Not defined: no PAR state, frame length is WIDTH, and the parity logic is absent.

## Test plan
- Reset check: assert rst mid-simulation, asynchronously between edges. Outputs go to sout=0, sframe=0, done=0, din_ready=0 immediately. After release, din_ready=1.
- Single word, WIDTH=8, no parity: din=8'hA5 with a one-cycle valid, accepted at edge 0.
  - sout reads 1,0,1,0,0,1,0,1 in cycles 1..8, with sframe high for cycles 1..8.
  - done=1 in cycle 9 only, and sout=0 in cycle 9.
- Back-to-back: offer 8'h01 then 8'hFF with din_valid held.
  - sframe is high continuously for cycles 1..16.
  - sout reads 1,0×7 then 1×8.
  - done pulses in cycle 9 and cycle 17.
  - din_ready is high only in cycles 0 and 8 during the stream.
- Busy ignore: hold din_valid=1 with changing din during cycles 2..7 of a frame. No accept occurs and the in-flight word is unaffected. The next word is taken at cycle 8.
- Mid-frame reset: pulse rst during cycle 4 of 8'hF0.
  - sframe drops immediately and no done pulse occurs.
  - A subsequent 8'h3C transmits correctly: 0,0,1,1,1,1,0,0.
- Parity (PISO_PARITY_EN):
  - din=8'h07 gives 9 frame bits, 1,1,1,0,0,0,0,0 then parity 1, with done in cycle 10.
  - din=8'h03 gives parity 0.

Source files
------------

// File: rtl/piso_shift_transmitter.sv
// -----------------------------------------------------------------------------
// piso_shift_transmitter
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is taken over a
// ready/valid handshake and shifted out LSB-first, one bit per clock. sframe
// marks every cycle that carries a frame bit. done pulses for one cycle right
// after the last frame bit. Back-to-back words stream with no idle gap.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit (^data)
// after the MSB. This adds the PAR state and makes frames WIDTH+1 bits long.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   din        in   [WIDTH-1:0] parallel word, sampled only on accept
//   din_valid  in   upstream presents a word on din
//   din_ready  out  block can accept a word this cycle (combinational)
//   sout       out  registered serial data, LSB first; 0 when idle
//   sframe     out  registered, high while sout carries a frame bit
//   done       out  registered one-cycle pulse after the last frame bit
//   dbg_state  out  [1:0] current FSM state (IDLE=0, SHIFT=1, PAR=2)
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
// din_ready is derived only from state (and rst), never from din_valid. While
// din_ready is low, din_valid is ignored. The upstream holds din and din_valid
// stable until the word is accepted.
// -----------------------------------------------------------------------------
module piso_shift_transmitter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sframe,
   output logic             done,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PISO_PARITY_EN
      ,
      PAR   = 2'd2
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             sframe_q, sframe_d;
   logic             done_q, done_d;
`ifdef PISO_PARITY_EN
   logic             par_q, par_d;
`endif

   logic accept;

   // Ready is open when idle, or in the cycle carrying the final frame bit,
   // so the next word starts with no gap.
   always_comb begin
      din_ready = 1'b0;
      case (state_q)
         IDLE:    din_ready = !rst;
`ifdef PISO_PARITY_EN
         PAR:     din_ready = 1'b1;
`else
         SHIFT:   din_ready = (cnt_q == LAST);
`endif
         default: din_ready = 1'b0;
      endcase
   end

   assign accept = din_valid && din_ready;

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      sout_d   = sout_q;
      sframe_d = sframe_q;
      done_d   = 1'b0;
`ifdef PISO_PARITY_EN
      par_d    = par_q;
`endif

      // frame_end: this edge ends the final bit of the current frame.
      case (state_q)
         SHIFT: begin
            if (cnt_q != LAST) begin
               sout_d = sreg_q[0];
               sreg_d = sreg_q >> 1;
               cnt_d  = cnt_q + CW'(1);
            end else begin
`ifdef PISO_PARITY_EN
               sout_d  = par_q;
               state_d = PAR;
`else
               done_d   = 1'b1;
               sout_d   = 1'b0;
               sframe_d = 1'b0;
               state_d  = IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            done_d   = 1'b1;
            sout_d   = 1'b0;
            sframe_d = 1'b0;
            state_d  = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // An accepted word overrides the idle return: bit 0 goes out next cycle.
      if (accept) begin
         sout_d   = din[0];
         sframe_d = 1'b1;
         sreg_d   = din >> 1;
         cnt_d    = '0;
         state_d  = SHIFT;
`ifdef PISO_PARITY_EN
         par_d    = ^din;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         sout_q   <= 1'b0;
         sframe_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         sout_q   <= sout_d;
         sframe_q <= sframe_d;
         done_q   <= done_d;
`ifdef PISO_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign sout      = sout_q;
   assign sframe    = sframe_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule
